// File: rtl/restador_serie_if.sv
// Handshake/operand bundle for restador_serie.
// Optional overflow flag V exists only when RESTADOR_OVF_EN is defined.
interface restador_serie_if #(
    parameter int WIDTH = 8
);
    logic             inicio;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Bi;
    logic [WIDTH-1:0] D;
    logic             Bo;
    logic             ocupado;
    logic             listo;
`ifdef RESTADOR_OVF_EN
    logic             V;

    modport master (output inicio, A, B, Bi, input D, Bo, ocupado, listo, V);
    modport slave  (input inicio, A, B, Bi, output D, Bo, ocupado, listo, V);
`else
    modport master (output inicio, A, B, Bi, input D, Bo, ocupado, listo);
    modport slave  (input inicio, A, B, Bi, output D, Bo, ocupado, listo);
`endif
endinterface

// File: rtl/restador_serie.sv
// Bit-serial subtractor D = A - B - Bi, LSB first, one bit per clock.
// Define RESTADOR_OVF_EN to add the signed-overflow flag V.
//
// state | meaning
// IDLE  | waiting for inicio; operands latched on the accepting edge
// RESTA | one result bit per edge, WIDTH edges
// FIN   | listo pulse; back to IDLE on the next edge
module restador_serie #(
    parameter int WIDTH = 8
) (
    input logic            clk,
    input logic            rst_n,
    restador_serie_if.slave bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RESTA, FIN} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic             bw;
    logic [CW-1:0]    cnt;

    logic a_bit, b_bit, d_bit, bw_next;

    assign a_bit   = a_sr[0];
    assign b_bit   = b_sr[0];
    assign d_bit   = a_bit ^ b_bit ^ bw;
    assign bw_next = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & bw);

    // Result bits enter a_sr at the MSB as minuend bits leave at the LSB,
    // so the minuend register doubles as the result shift register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            a_sr        <= '0;
            b_sr        <= '0;
            bw          <= 1'b0;
            cnt         <= '0;
            bus.D       <= '0;
            bus.Bo      <= 1'b0;
            bus.ocupado <= 1'b0;
            bus.listo   <= 1'b0;
`ifdef RESTADOR_OVF_EN
            bus.V       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    bus.listo <= 1'b0;
                    if (bus.inicio) begin
                        a_sr        <= bus.A;
                        b_sr        <= bus.B;
                        bw          <= bus.Bi;
                        cnt         <= '0;
                        bus.ocupado <= 1'b1;
                        state       <= RESTA;
                    end
                end
                RESTA: begin
                    a_sr <= {d_bit, a_sr[WIDTH-1:1]};
                    b_sr <= {1'b0, b_sr[WIDTH-1:1]};
                    bw   <= bw_next;
                    if (cnt == LAST) begin
                        cnt         <= '0;
                        bus.D       <= {d_bit, a_sr[WIDTH-1:1]};
                        bus.Bo      <= bw_next;
`ifdef RESTADOR_OVF_EN
                        // borrow into the MSB vs borrow out of it
                        bus.V       <= bw ^ bw_next;
`endif
                        bus.ocupado <= 1'b0;
                        bus.listo   <= 1'b1;
                        state       <= FIN;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                FIN: begin
                    bus.listo <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    bus.listo   <= 1'b0;
                    bus.ocupado <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_restador_serie.sv
// Self-checking bench for restador_serie (WIDTH=8): vector table, random ops
// against an arithmetic model, ignored-request and mid-operation reset sequences.
module tb_restador_serie;
    localparam int WIDTH = 8;

    logic clk;
    logic rst_n;

    restador_serie_if #(.WIDTH(WIDTH)) bus ();

    restador_serie #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       bi;
        logic [7:0] d;
        logic       bo;
        logic       v;
    } vec_t;

    vec_t       vecs[6];
    int         tests = 0;
    int         fails = 0;
    logic [7:0] prev_d;
    logic       prev_bo;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the whole operands.
    function automatic void model(input logic [7:0] a, input logic [7:0] b, input logic bi,
                                  output logic [7:0] d, output logic bo, output logic v);
        int r;
        d  = a - b - 8'(bi);
        bo = (int'(a) < int'(b) + int'(bi));
        r  = int'($signed(a)) - int'($signed(b)) - int'(bi);
        v  = (r < -128) || (r > 127);
    endfunction

    // noise: 0 none, 1 random inicio/operands while busy, 2 pulses on cycles 3 and 9
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic bi,
                          input logic [7:0] ed, input logic ebo, input logic ev,
                          input int noise, input string tag);
        int n;
        int occ;
        bit got;
        bit held;
        @(negedge clk);
        bus.A = a; bus.B = b; bus.Bi = bi; bus.inicio = 1'b1;
        @(posedge clk);
        #1;
        bus.inicio = 1'b0;
        bus.A = 8'($urandom); bus.B = 8'($urandom); bus.Bi = 1'($urandom);
        n = 0; occ = 0; got = 0; held = 1;
        while (!got && n < 30) begin
            @(negedge clk);
            n++;
            if (bus.ocupado) occ++;
            if (bus.listo) got = 1;
            else if (bus.D !== prev_d || bus.Bo !== prev_bo) held = 0;
            if (noise == 1) begin
                bus.inicio = got ? 1'b0 : 1'($urandom);
                bus.A = 8'($urandom); bus.B = 8'($urandom); bus.Bi = 1'($urandom);
            end else if (noise == 2) begin
                bus.inicio = (n == 3 || n == 9);
                bus.A = 8'hAA; bus.B = 8'h55; bus.Bi = 1'b0;
            end
        end
        check({tag, " listo_seen"}, 32'(got), 32'd1);
        if (got) begin
            check({tag, " latency"}, 32'(n), 32'd9);
            check({tag, " ocupado_cycles"}, 32'(occ), 32'd8);
            check({tag, " D"}, 32'(bus.D), 32'(ed));
            check({tag, " Bo"}, 32'(bus.Bo), 32'(ebo));
            check({tag, " prev_held"}, 32'(held), 32'd1);
`ifdef RESTADOR_OVF_EN
            check({tag, " V"}, 32'(bus.V), 32'(ev));
`else
            if (ev === 1'bx) $display("note: V undefined");
`endif
        end
        @(negedge clk);
        bus.inicio = 1'b0;
        check({tag, " listo_one_cycle"}, 32'(bus.listo), 32'd0);
        check({tag, " idle_after"}, 32'(bus.ocupado), 32'd0);
        check({tag, " D_hold"}, 32'(bus.D), 32'(ed));
        prev_d  = ed;
        prev_bo = ebo;
    endtask

    initial begin
        logic [7:0] md;
        logic       mbo, mv;
        logic [7:0] ra, rb;
        logic       rbi;
        bit         stray;

        vecs[0] = '{a: 8'h05, b: 8'h03, bi: 1'b0, d: 8'h02, bo: 1'b0, v: 1'b0};
        vecs[1] = '{a: 8'h03, b: 8'h05, bi: 1'b0, d: 8'hFE, bo: 1'b1, v: 1'b0};
        vecs[2] = '{a: 8'h00, b: 8'h00, bi: 1'b1, d: 8'hFF, bo: 1'b1, v: 1'b0};
        vecs[3] = '{a: 8'hFF, b: 8'hFF, bi: 1'b1, d: 8'hFF, bo: 1'b1, v: 1'b0};
        vecs[4] = '{a: 8'h80, b: 8'h01, bi: 1'b0, d: 8'h7F, bo: 1'b0, v: 1'b1};
        vecs[5] = '{a: 8'h7F, b: 8'h01, bi: 1'b0, d: 8'h7E, bo: 1'b0, v: 1'b0};

        rst_n = 1'b0;
        bus.inicio = 1'b0; bus.A = '0; bus.B = '0; bus.Bi = 1'b0;
        prev_d = 8'h00; prev_bo = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset D", 32'(bus.D), 32'd0);
        check("reset Bo", 32'(bus.Bo), 32'd0);
        check("reset ocupado", 32'(bus.ocupado), 32'd0);
        check("reset listo", 32'(bus.listo), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++)
            run_op(vecs[i].a, vecs[i].b, vecs[i].bi, vecs[i].d, vecs[i].bo, vecs[i].v,
                   0, $sformatf("vec%0d", i));

        // requests during RESTA and FIN are dropped, not queued
        run_op(8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 1'b0, 2, "ignore");
        repeat (3) @(negedge clk);
        check("ignore no_restart", 32'(bus.ocupado), 32'd0);
        check("ignore D_still", 32'(bus.D), 32'h0F);

        for (int i = 0; i < 30; i++) begin
            ra = 8'($urandom); rb = 8'($urandom); rbi = 1'($urandom);
            if (i == 0) begin ra = 8'h00; rb = 8'hFF; rbi = 1'b1; end
            model(ra, rb, rbi, md, mbo, mv);
            run_op(ra, rb, rbi, md, mbo, mv, (i % 2), $sformatf("rnd%0d", i));
        end

        // reset in the middle of an operation
        @(negedge clk);
        bus.A = 8'h33; bus.B = 8'h11; bus.Bi = 1'b0; bus.inicio = 1'b1;
        @(negedge clk);
        bus.inicio = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_reset busy", 32'(bus.ocupado), 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort D", 32'(bus.D), 32'd0);
        check("abort Bo", 32'(bus.Bo), 32'd0);
        check("abort ocupado", 32'(bus.ocupado), 32'd0);
        check("abort listo", 32'(bus.listo), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        stray = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.listo || bus.ocupado) stray = 1;
        end
        check("abort no_listo", 32'(stray), 32'd0);
        prev_d = 8'h00; prev_bo = 1'b0;
        run_op(8'h20, 8'h10, 1'b0, 8'h10, 1'b0, 1'b0, 0, "post_reset");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
